// File: rtl/lut3d_trilinear_interp_if.sv
// Pixel stream into and out of the trilinear interpolator.
// master drives corners/fractions and consumes the result; slave is the interpolator.
interface lut3d_trilinear_interp_if #(
    parameter int unsigned LUT_CD   = 8,
    parameter int unsigned FRAC_BIT = 3,
    parameter int unsigned USER_W   = 4
);
    logic                          i_valid;
    logic [7:0][3*LUT_CD-1:0]      i_nbr;
    logic [FRAC_BIT-1:0]           i_frac_r;
    logic [FRAC_BIT-1:0]           i_frac_g;
    logic [FRAC_BIT-1:0]           i_frac_b;
    logic [USER_W-1:0]             i_user;
    logic                          o_valid;
    logic [3*LUT_CD-1:0]           o_data;
    logic [USER_W-1:0]             o_user;

    modport master (
        output i_valid, i_nbr, i_frac_r, i_frac_g, i_frac_b, i_user,
        input  o_valid, o_data, o_user
    );

    modport slave (
        input  i_valid, i_nbr, i_frac_r, i_frac_g, i_frac_b, i_user,
        output o_valid, o_data, o_user
    );
endinterface

// File: rtl/lut3d_trilinear_interp.sv
// Trilinear interpolation of 8 LUT lattice corners: R-lerps, then G-lerps, then one B-lerp,
// one register stage each, 3-cycle latency, one pixel per clock, no backpressure.
module lut3d_trilinear_interp #(
    parameter int unsigned LUT_CD   = 8,
    parameter int unsigned FRAC_BIT = 3,
    parameter int unsigned USER_W   = 4
) (
    input logic                      clk,
    input logic                      rstn,
    lut3d_trilinear_interp_if.slave  bus
);
    localparam int unsigned EW = 3 * LUT_CD;
    localparam int unsigned IW = LUT_CD + FRAC_BIT + 1;
    localparam logic [IW-1:0] ONE  = IW'(1) << FRAC_BIT;
    localparam logic [IW-1:0] HALF = IW'(1) << (FRAC_BIT - 1);

    // Half-up rounded lerp. f==0 must return a untouched: b is don't-care from the RAM stage
    // when the lattice index sits on the last grid point.
    function automatic logic [LUT_CD-1:0] lerp(input logic [LUT_CD-1:0]   a,
                                               input logic [LUT_CD-1:0]   b,
                                               input logic [FRAC_BIT-1:0] f);
        logic [IW-1:0] acc;
        acc = IW'(a) * (ONE - IW'(f)) + IW'(b) * IW'(f) + HALF;
        if (f == '0) begin
            lerp = a;
        end else begin
            lerp = LUT_CD'(acc >> FRAC_BIT);
        end
    endfunction

    logic [3:0][EW-1:0]  s1_d, s1_q;
    logic [FRAC_BIT-1:0] s1_fg_q, s1_fb_q;
    logic [USER_W-1:0]   s1_user_q;
    logic                s1_valid_q;

    logic [1:0][EW-1:0]  s2_d, s2_q;
    logic [FRAC_BIT-1:0] s2_fb_q;
    logic [USER_W-1:0]   s2_user_q;
    logic                s2_valid_q;

    logic [EW-1:0]       s3_d, s3_q;
    logic [USER_W-1:0]   s3_user_q;
    logic                s3_valid_q;

    // Stage 1 next-state: R-lerps between corner pairs differing only in the R index bit.
    always_comb begin
        s1_d = '0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 3; c++) begin
                s1_d[k][c*LUT_CD +: LUT_CD] = lerp(bus.i_nbr[2*k][c*LUT_CD +: LUT_CD],
                                                   bus.i_nbr[2*k+1][c*LUT_CD +: LUT_CD],
                                                   bus.i_frac_r);
            end
        end
    end

    // Stage 2 next-state: G-lerps between the R results.
    always_comb begin
        s2_d = '0;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 3; c++) begin
                s2_d[k][c*LUT_CD +: LUT_CD] = lerp(s1_q[2*k][c*LUT_CD +: LUT_CD],
                                                   s1_q[2*k+1][c*LUT_CD +: LUT_CD],
                                                   s1_fg_q);
            end
        end
    end

    // Stage 3 next-state: final B-lerp.
    always_comb begin
        s3_d = '0;
        for (int c = 0; c < 3; c++) begin
            s3_d[c*LUT_CD +: LUT_CD] = lerp(s2_q[0][c*LUT_CD +: LUT_CD],
                                            s2_q[1][c*LUT_CD +: LUT_CD],
                                            s2_fb_q);
        end
    end

    // Valid chain always advances so bubbles travel through unchanged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= bus.i_valid;
            s2_valid_q <= s1_valid_q;
            s3_valid_q <= s2_valid_q;
        end
    end

    // Stage 1 data: loads only on a valid pixel, holds otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q      <= '0;
            s1_fg_q   <= '0;
            s1_fb_q   <= '0;
            s1_user_q <= '0;
        end else if (bus.i_valid) begin
            s1_q      <= s1_d;
            s1_fg_q   <= bus.i_frac_g;
            s1_fb_q   <= bus.i_frac_b;
            s1_user_q <= bus.i_user;
        end
    end

    // Stage 2 data: loads only when stage 1 holds a valid pixel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_q      <= '0;
            s2_fb_q   <= '0;
            s2_user_q <= '0;
        end else if (s1_valid_q) begin
            s2_q      <= s2_d;
            s2_fb_q   <= s1_fb_q;
            s2_user_q <= s1_user_q;
        end
    end

    // Output registers: load only when stage 2 holds a valid pixel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s3_q      <= '0;
            s3_user_q <= '0;
        end else if (s2_valid_q) begin
            s3_q      <= s3_d;
            s3_user_q <= s2_user_q;
        end
    end

    assign bus.o_valid = s3_valid_q;
    assign bus.o_data  = s3_q;
    assign bus.o_user  = s3_user_q;
endmodule
